// File: rtl/fpdiv_issue_ctrl.sv
// Issue/collect sequencer in front of the fpdiv start/done divider.
// One operation in flight; results (or timeout markers) are queued in a small FIFO.
module fpdiv_issue_ctrl #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 16,
    parameter int TAG_W        = 4,
    parameter int DEPTH        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_op1,
    input  logic [63:0]      req_op2,
    input  logic [2:0]       req_rm,
    input  logic             req_op_type,
    input  logic             req_P,
    input  logic             req_OvEn,
    input  logic             req_UnEn,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [63:0]      div_op1,
    output logic [63:0]      div_op2,
    output logic [2:0]       div_rm,
    output logic             div_op_type,
    output logic             div_P,
    output logic             div_OvEn,
    output logic             div_UnEn,
    input  logic             div_done,
    input  logic [63:0]      div_result,
    input  logic [4:0]       div_flags,
    input  logic             div_denorm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_denorm,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    // state   | meaning
    // S_IDLE  | no operation in flight, may accept a request
    // S_START | div_start asserted, counting START_CYCLES
    // S_WAIT  | waiting for a done rising edge or timeout

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int ST_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0]  ST_LAST = ST_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_done_q;
    logic [TO_W-1:0]  r_to_cnt;
    logic [ST_W-1:0]  r_st_cnt;
    logic [TAG_W-1:0] r_tag;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [63:0]      r_mem_result [DEPTH];
    logic [4:0]       r_mem_flags  [DEPTH];
    logic             r_mem_denorm [DEPTH];
    logic             r_mem_tout   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag    [DEPTH];

    logic w_accept;
    logic w_active;
    logic w_done_evt;
    logic w_to_evt;
    logic w_push;
    logic w_pop;
    logic w_nonempty;

    assign w_active   = (r_state != S_IDLE);
    assign w_nonempty = (r_count != '0);
    assign req_ready  = reset && (r_state == S_IDLE) && (r_count < FULL);
    assign w_accept   = req_valid && req_ready;
    // Rising-edge detect keeps a level-high done left over from a prior op from being taken.
    assign w_done_evt = w_active && div_done && !r_done_q;
    assign w_to_evt   = w_active && !w_done_evt && (r_to_cnt == TO_LAST);
    assign w_push     = w_done_evt || w_to_evt;
    assign w_pop      = w_nonempty && rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        div_start   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                div_start = 1'b1;
                busy      = 1'b1;
                if (w_push) begin
                    w_state_nxt = S_IDLE;
                end else if (r_st_cnt == ST_LAST) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_push) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_done_q <= 1'b0;
            r_to_cnt <= '0;
            r_st_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= div_done;
            if (w_accept) begin
                r_to_cnt <= '0;
                r_st_cnt <= '0;
            end else if (w_active) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_state == S_START) begin
                    r_st_cnt <= r_st_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_op1     <= '0;
            div_op2     <= '0;
            div_rm      <= '0;
            div_op_type <= 1'b0;
            div_P       <= 1'b0;
            div_OvEn    <= 1'b0;
            div_UnEn    <= 1'b0;
            r_tag       <= '0;
        end else if (w_accept) begin
            div_op1     <= req_op1;
            div_op2     <= req_op2;
            div_rm      <= req_rm;
            div_op_type <= req_op_type;
            div_P       <= req_P;
            div_OvEn    <= req_OvEn;
            div_UnEn    <= req_UnEn;
            r_tag       <= req_tag;
        end
    end

    // Overflow is impossible: accept requires a free slot and only one op is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= w_done_evt ? div_result : 64'd0;
            r_mem_flags[r_wr_ptr]  <= w_done_evt ? div_flags : 5'd0;
            r_mem_denorm[r_wr_ptr] <= w_done_evt ? div_denorm : 1'b0;
            r_mem_tout[r_wr_ptr]   <= !w_done_evt;
            r_mem_tag[r_wr_ptr]    <= r_tag;
        end
    end

    assign rsp_valid   = w_nonempty;
    assign rsp_result  = w_nonempty ? r_mem_result[r_rd_ptr] : 64'd0;
    assign rsp_flags   = w_nonempty ? r_mem_flags[r_rd_ptr]  : 5'd0;
    assign rsp_denorm  = w_nonempty ? r_mem_denorm[r_rd_ptr] : 1'b0;
    assign rsp_timeout = w_nonempty ? r_mem_tout[r_rd_ptr]   : 1'b0;
    assign rsp_tag     = w_nonempty ? r_mem_tag[r_rd_ptr]    : '0;

endmodule
